wr_req_arbiter: RTL and testbench
=================================

// Module: wr_req_arbiter
// PURPOSE
//  Slave-side end of the crossbar write-request path: merges write requests from two
//  master-side switch outputs onto one slave port. Round-robin arbitration; the grant
//  is held until the slave acknowledges. The ack is steered back to the granted master.
//  One instance sits in front of each slave.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  write data width
//  TIMEOUT_CYC  16  slave-ack timeout in cycles (used only with WR_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1       clock; all logic on rising edge
//  rst        in   1       reset, asynchronous, active-high
//  m0_req     in   1       master 0 write request; held high until m0_ack/m0_err
//  m0_addr    in   ADDR_W  master 0 address
//  m0_wdata   in   DATA_W  master 0 write data
//  m0_ack     out  1       master 0 done pulse (combinational from s_ack)
//  m0_err     out  1       master 0 timeout pulse (constant 0 without macro)
//  m1_req     in   1       master 1 write request
//  m1_addr    in   ADDR_W  master 1 address
//  m1_wdata   in   DATA_W  master 1 write data
//  m1_ack     out  1       master 1 done pulse
//  m1_err     out  1       master 1 timeout pulse
//  s_req      out  1       slave write request (registered)
//  s_addr     out  ADDR_W  slave address (registered, latched at grant)
//  s_wdata    out  DATA_W  slave write data (registered, latched at grant)
//  s_master   out  1       index of the granted master (registered)
//  s_ack      in   1       slave accepts the write while s_req=1
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; s_req=0, s_addr=0, s_wdata=0, s_master=0;
//    last_grant=1 (master 0 wins the first tie); timeout counter=0. An in-flight write is
//    dropped; no ack or err is issued for it.
//  - FSM IDLE: the winner is chosen each cycle. Both req -> !last_grant; one req -> that
//    master; none -> stay in IDLE.
//    On a grant edge: latch the winner's addr/wdata into s_addr/s_wdata,
//    s_master=winner, s_req=1, go to BUSY. Latency: req sampled at edge k -> s_req high
//    after edge k.
//  - FSM BUSY: s_req, s_addr, s_wdata and s_master are frozen. Master input changes and
//    the other master's req are ignored.
//    mN_ack = s_ack & (state==BUSY) & (s_master==N), with no added cycle.
//    On an edge with s_ack=1: s_req=0, last_grant=s_master, go to IDLE.
//  - s_ack in IDLE is ignored and produces no ack.
//  - Masters drop req on the edge where they sample ack=1. IDLE therefore never re-grants
//    a completed request.
//  - Minimum transaction: 2 cycles (grant cycle, then an ack cycle). Back-to-back grants
//    alternate masters when both keep requesting.
//  - A master that drops req mid-BUSY is a protocol violation. The transaction still
//    completes and the ack pulse is still issued.
//  - s_addr and s_wdata keep their last values after completion. Only s_req qualifies them.
// CONFIGURATION
//  WR_ARB_TIMEOUT_EN defined:
//  - The counter clears on entry to BUSY and increments on each BUSY cycle without s_ack.
//  - If it reaches TIMEOUT_CYC-1 with s_ack=0: s_req=0, mN_err pulses for 1 cycle
//    (combinational, that same cycle), last_grant=s_master, go to IDLE. mN_ack stays 0.
//  - s_ack in the timeout cycle takes priority: normal ack, no err.
//  WR_ARB_TIMEOUT_EN undefined: no counter; m0_err=m1_err=0; BUSY waits indefinitely.
// TESTING
//  1 rst=1 with no clock -> s_req=0, s_addr=0, s_wdata=0, s_master=0, m0/m1_ack=0 immediately
//  2 m0_req, addr=0x10, wdata=0xDEADBEEF; s_ack 2 cycles after s_req -> s_req high after
//    1 edge, s_addr=0x10, s_master=0; m0_ack=1 only in the s_ack cycle; IDLE next cycle
//  3 m0_req and m1_req together after reset, both held 4 transactions -> s_master
//    sequence 0,1,0,1; each ack reaches only its own master
//  4 m0 granted, then m1_req, and m0_addr changed to 0x20 during BUSY -> s_addr stays
//    0x10; m1 granted on the edge after m0's ack cycle
//  5 rst asserted in BUSY -> s_req=0 at once, no ack; after release with both req held,
//    master 0 is granted first
//  6 macro on, TIMEOUT_CYC=16, no s_ack -> s_req high 16 cycles, m0_err pulses, m0_ack=0;
//    macro off -> s_req held 100+ cycles, m0_err=0

Source files
------------

// File: rtl/wr_req_arbiter.sv
// Two-master round-robin write-request arbiter in front of one slave port.
// Optional slave-ack timeout is enabled with the macro WR_ARB_TIMEOUT_EN.
module wr_req_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              s_req,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_master,
    input  logic              s_ack
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              s_req_n;
    logic [ADDR_W-1:0] s_addr_n;
    logic [DATA_W-1:0] s_wdata_n;
    logic              s_master_n;
    logic              last_grant;
    logic              last_grant_n;
    logic              winner;
    logic              ack_c;
    logic              err_c;

`ifdef WR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             cnt_last;

    assign cnt_last = (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cyc;

    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    // Round-robin pick: on a tie the master not served last wins.
    always_comb begin
        if (m0_req && m1_req) begin
            winner = ~last_grant;
        end else begin
            winner = m1_req;
        end
    end

    // Next-state and completion logic.
    always_comb begin
        state_n      = state;
        s_req_n      = s_req;
        s_addr_n     = s_addr;
        s_wdata_n    = s_wdata;
        s_master_n   = s_master;
        last_grant_n = last_grant;
        ack_c        = 1'b0;
        err_c        = 1'b0;
`ifdef WR_ARB_TIMEOUT_EN
        cnt_n        = cnt;
`endif

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_n    = BUSY;
                    s_req_n    = 1'b1;
                    s_addr_n   = winner ? m1_addr : m0_addr;
                    s_wdata_n  = winner ? m1_wdata : m0_wdata;
                    s_master_n = winner;
`ifdef WR_ARB_TIMEOUT_EN
                    cnt_n      = '0;
`endif
                end
            end
            BUSY: begin
                if (s_ack) begin
                    ack_c        = 1'b1;
                    state_n      = IDLE;
                    s_req_n      = 1'b0;
                    last_grant_n = s_master;
                end
`ifdef WR_ARB_TIMEOUT_EN
                else if (cnt_last) begin
                    err_c        = 1'b1;
                    state_n      = IDLE;
                    s_req_n      = 1'b0;
                    last_grant_n = s_master;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
`endif
            end
        endcase
    end

    // State and registered slave-side outputs; reset drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            s_req      <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_master   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_n;
            s_req      <= s_req_n;
            s_addr     <= s_addr_n;
            s_wdata    <= s_wdata_n;
            s_master   <= s_master_n;
            last_grant <= last_grant_n;
        end
    end

`ifdef WR_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_n;
        end
    end
`endif

    // Completion pulses steered to the granted master in the same cycle.
    assign m0_ack = ack_c & ~s_master;
    assign m1_ack = ack_c & s_master;
    assign m0_err = err_c & ~s_master;
    assign m1_err = err_c & s_master;

endmodule

// File: tb/tb_wr_req_arbiter.sv
// Directed bench for wr_req_arbiter; expectations follow WR_ARB_TIMEOUT_EN when defined.
module tb_wr_req_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk;
    logic              clk_run;
    logic              rst;
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m0_err;
    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic              m1_err;
    logic              s_req;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_master;
    logic              s_ack;

    int total;
    int bad;

    wr_req_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_req  (m0_req),
        .m0_addr (m0_addr),
        .m0_wdata(m0_wdata),
        .m0_ack  (m0_ack),
        .m0_err  (m0_err),
        .m1_req  (m1_req),
        .m1_addr (m1_addr),
        .m1_wdata(m1_wdata),
        .m1_ack  (m1_ack),
        .m1_err  (m1_err),
        .s_req   (s_req),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_master(s_master),
        .s_ack   (s_ack)
    );

    initial clk = 1'b0;
    always #5 if (clk_run) clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        clk_run  = 1'b0;
        rst      = 1'b1;
        m0_req   = 1'b0;
        m0_addr  = '0;
        m0_wdata = '0;
        m1_req   = 1'b0;
        m1_addr  = '0;
        m1_wdata = '0;
        s_ack    = 1'b0;

        // 1: reset values with no clock running
        #2;
        chk("rst_s_req", 64'(s_req), 64'd0);
        chk("rst_s_addr", 64'(s_addr), 64'd0);
        chk("rst_s_wdata", 64'(s_wdata), 64'd0);
        chk("rst_s_master", 64'(s_master), 64'd0);
        chk("rst_m0_ack", 64'(m0_ack), 64'd0);
        chk("rst_m1_ack", 64'(m1_ack), 64'd0);
        clk_run = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // s_ack while idle is ignored
        s_ack = 1'b1;
        #1;
        chk("idle_ack_m0", 64'(m0_ack), 64'd0);
        chk("idle_ack_m1", 64'(m1_ack), 64'd0);
        tick();
        chk("idle_ack_sreq", 64'(s_req), 64'd0);
        s_ack = 1'b0;

        // 2: single m0 write, ack two cycles after s_req
        m0_req   = 1'b1;
        m0_addr  = 32'h10;
        m0_wdata = 32'hDEADBEEF;
        tick();
        chk("t2_sreq", 64'(s_req), 64'd1);
        chk("t2_addr", 64'(s_addr), 64'h10);
        chk("t2_wdata", 64'(s_wdata), 64'hDEADBEEF);
        chk("t2_master", 64'(s_master), 64'd0);
        chk("t2_noack", 64'(m0_ack), 64'd0);
        tick();
        chk("t2_sreq_hold", 64'(s_req), 64'd1);
        chk("t2_noack2", 64'(m0_ack), 64'd0);
        s_ack = 1'b1;
        #1;
        chk("t2_m0_ack", 64'(m0_ack), 64'd1);
        chk("t2_m1_ack", 64'(m1_ack), 64'd0);
        tick();
        m0_req = 1'b0;
        s_ack  = 1'b0;
        chk("t2_idle", 64'(s_req), 64'd0);
        chk("t2_ack_gone", 64'(m0_ack), 64'd0);
        chk("t2_addr_kept", 64'(s_addr), 64'h10);

        // 3: both request after reset, alternation 0,1,0,1
        rst = 1'b1;
        #1;
        rst      = 1'b0;
        m0_addr  = 32'h100;
        m1_addr  = 32'h200;
        m0_wdata = 32'hA0A0A0A0;
        m1_wdata = 32'hB1B1B1B1;
        m0_req   = 1'b1;
        m1_req   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_sreq", 64'(s_req), 64'd1);
            chk("t3_master", 64'(s_master), 64'(i % 2));
            chk("t3_addr", 64'(s_addr), (i % 2 == 0) ? 64'h100 : 64'h200);
            s_ack = 1'b1;
            #1;
            chk("t3_m0_ack", 64'(m0_ack), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("t3_m1_ack", 64'(m1_ack), (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            s_ack = 1'b0;
            chk("t3_idle", 64'(s_req), 64'd0);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;

        // 4: BUSY freezes payload; m1 served after m0 completes
        rst = 1'b1;
        #1;
        rst     = 1'b0;
        m0_req  = 1'b1;
        m0_addr = 32'h10;
        tick();
        chk("t4_master0", 64'(s_master), 64'd0);
        m1_req  = 1'b1;
        m0_addr = 32'h20;
        m1_addr = 32'h30;
        tick();
        chk("t4_addr_frozen", 64'(s_addr), 64'h10);
        chk("t4_master_frozen", 64'(s_master), 64'd0);
        s_ack = 1'b1;
        #1;
        chk("t4_m0_ack", 64'(m0_ack), 64'd1);
        chk("t4_m1_ack", 64'(m1_ack), 64'd0);
        tick();
        m0_req = 1'b0;
        s_ack  = 1'b0;
        chk("t4_idle", 64'(s_req), 64'd0);
        tick();
        chk("t4_m1_grant", 64'(s_master), 64'd1);
        chk("t4_m1_addr", 64'(s_addr), 64'h30);
        s_ack = 1'b1;
        #1;
        chk("t4_m1_ack", 64'(m1_ack), 64'd1);
        tick();
        m1_req = 1'b0;
        s_ack  = 1'b0;

        // 5: reset during BUSY drops the write; master 0 wins afterwards
        m0_req = 1'b1;
        tick();
        s_ack = 1'b1;
        tick();
        s_ack  = 1'b0;
        m1_req = 1'b1;
        tick();
        chk("t5_m1_grant", 64'(s_master), 64'd1);
        rst   = 1'b1;
        s_ack = 1'b1;
        #1;
        chk("t5_rst_sreq", 64'(s_req), 64'd0);
        chk("t5_rst_master", 64'(s_master), 64'd0);
        chk("t5_rst_addr", 64'(s_addr), 64'd0);
        chk("t5_rst_m0_ack", 64'(m0_ack), 64'd0);
        chk("t5_rst_m1_ack", 64'(m1_ack), 64'd0);
        s_ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("t5_first_m0", 64'(s_master), 64'd0);
        chk("t5_sreq", 64'(s_req), 64'd1);
        s_ack = 1'b1;
        tick();
        s_ack  = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();

        // 6: slave never acks
        m0_req = 1'b1;
        tick();
`ifdef WR_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            chk("t6_busy_sreq", 64'(s_req), 64'd1);
            chk("t6_early_err", 64'(m0_err), 64'd0);
            tick();
        end
        chk("t6_last_sreq", 64'(s_req), 64'd1);
        chk("t6_m0_err", 64'(m0_err), 64'd1);
        chk("t6_m1_err", 64'(m1_err), 64'd0);
        chk("t6_m0_ack", 64'(m0_ack), 64'd0);
        tick();
        m0_req = 1'b0;
        chk("t6_dropped", 64'(s_req), 64'd0);
        chk("t6_err_gone", 64'(m0_err), 64'd0);
        // ack in the timeout cycle wins over err
        m0_req = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        s_ack = 1'b1;
        #1;
        chk("t6_prio_ack", 64'(m0_ack), 64'd1);
        chk("t6_prio_err", 64'(m0_err), 64'd0);
        tick();
        s_ack  = 1'b0;
        m0_req = 1'b0;
        chk("t6_prio_idle", 64'(s_req), 64'd0);
`else
        for (int i = 0; i < 120; i++) begin
            chk("t6_held_sreq", 64'(s_req), 64'd1);
            chk("t6_no_err", 64'(m0_err), 64'd0);
            tick();
        end
        s_ack = 1'b1;
        #1;
        chk("t6_late_ack", 64'(m0_ack), 64'd1);
        tick();
        s_ack  = 1'b0;
        m0_req = 1'b0;
        chk("t6_idle", 64'(s_req), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
